// File: rtl/mlkem_pkg.sv
// Shared types, constants and reduction helpers for the ML-KEM NTT datapath.
// Barrett reduction is only instantiated by the butterfly when
// MLKEM_BFLY_INTT_EN is defined.
package mlkem_pkg;

  typedef logic signed [15:0] coeff_t;
  typedef logic signed [31:0] prod_t;

  localparam coeff_t      KYBER_Q     = 16'sd3329;
  localparam logic [15:0] QINV        = 16'd62209;
  localparam prod_t       BARRETT_V   = 32'sd20159;
  localparam prod_t       BARRETT_RND = 32'sd33554432;

  // Montgomery reduction: returns p * 2^-16 mod q, with |result| < q.
  // The low half of (p - u*q) is zero by construction, so the arithmetic
  // shift is exact.
  function automatic coeff_t mont_reduce(input prod_t p);
    logic [15:0] u_bits;
    coeff_t      u;
    prod_t       diff;
    u_bits = p[15:0] * QINV;
    u      = coeff_t'(u_bits);
    diff   = p - prod_t'(u) * prod_t'(KYBER_Q);
    return coeff_t'(diff >>> 16);
  endfunction

  // Barrett reduction to a centered representative of x mod q.
  function automatic coeff_t barrett_reduce(input coeff_t x);
    prod_t  num;
    coeff_t quo;
    num = prod_t'(x) * BARRETT_V + BARRETT_RND;
    quo = coeff_t'(num >>> 26);
    return x - quo * KYBER_Q;
  endfunction

endpackage

// File: rtl/mlkem_fqmul_stage.sv
// Two-stage Montgomery multiplier: S1 registers the signed 16x16 product,
// S2 registers the reduced result. Both stages advance only on i_en so the
// butterfly can stall the whole pipeline with one signal.
module mlkem_fqmul_stage
  import mlkem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic signed [15:0] i_zeta,
  input  logic signed [15:0] i_b,
  output logic signed [15:0] o_t
);

  prod_t  r_p;
  coeff_t r_t;

  // Product register (S1) followed by reduce register (S2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
      r_t <= '0;
    end else if (i_en) begin
      r_p <= prod_t'(i_zeta) * prod_t'(i_b);
      r_t <= mont_reduce(r_p);
    end
  end

  assign o_t = r_t;

endmodule

// File: rtl/mlkem_ntt_butterfly.sv
// Three-stage pipelined ML-KEM NTT butterfly with valid/ready on both sides.
// Default build: Cooley-Tukey only (a' = a + t, b' = a - t, t = fqmul(zeta, b)).
// With MLKEM_BFLY_INTT_EN defined, inv_in selects the Gentleman-Sande
// butterfly (a' = barrett(a + b), b' = fqmul(zeta, b - a)) per pair.
// The whole pipeline advances together; a full output slot that is not
// being taken freezes every stage.
module mlkem_ntt_butterfly
  import mlkem_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] a_in,
  input  logic signed [15:0] b_in,
  input  logic signed [15:0] zeta_in,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               inv_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] a_out,
  output logic signed [15:0] b_out,
  output logic [TAG_W-1:0]   tag_out
);

  logic             w_en;
  coeff_t           w_a_s0;
  coeff_t           w_b_s0;
  coeff_t           w_t;
  coeff_t           w_a_s3;
  coeff_t           w_b_s3;

  logic             r_v1, r_v2, r_v3;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  coeff_t           r_a1, r_a2;
  coeff_t           r_a_out, r_b_out;

  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

`ifdef MLKEM_BFLY_INTT_EN
  logic r_inv1, r_inv2;

  // GS pre-processing: the multiplier sees b-a and the a lane carries a+b.
  assign w_a_s0 = inv_in ? coeff_t'(a_in + b_in) : a_in;
  assign w_b_s0 = inv_in ? coeff_t'(b_in - a_in) : b_in;

  // Carry the butterfly kind alongside its pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv1 <= 1'b0;
      r_inv2 <= 1'b0;
    end else if (w_en) begin
      r_inv1 <= inv_in;
      r_inv2 <= r_inv1;
    end
  end
`else
  logic w_unused_inv;
  assign w_unused_inv = inv_in;
  assign w_a_s0       = a_in;
  assign w_b_s0       = b_in;
`endif

  mlkem_fqmul_stage u_fqmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_zeta (zeta_in),
    .i_b    (w_b_s0),
    .o_t    (w_t)
  );

  // S3 combine: add/sub with two's-complement wrap, or GS outputs.
  always_comb begin
    w_a_s3 = r_a2 + w_t;
    w_b_s3 = r_a2 - w_t;
`ifdef MLKEM_BFLY_INTT_EN
    if (r_inv2) begin
      w_a_s3 = barrett_reduce(r_a2);
      w_b_s3 = w_t;
    end
`endif
  end

  // Valid, tag and a-lane pipeline plus S3 output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_tag1  <= '0;
      r_tag2  <= '0;
      r_tag3  <= '0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_a_out <= '0;
      r_b_out <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      r_tag1  <= tag_in;
      r_tag2  <= r_tag1;
      r_tag3  <= r_tag2;
      r_a1    <= w_a_s0;
      r_a2    <= r_a1;
      r_a_out <= w_a_s3;
      r_b_out <= w_b_s3;
    end
  end

  assign out_valid = r_v3;
  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign tag_out   = r_tag3;

endmodule
